multi_digit_counter: RTL and testbench

MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

---
 rtl/multi_digit_counter_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 31 +++
 rtl/multi_digit_counter.sv | 113 +++++++++++
 tb/tb_multi_digit_counter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_digit_counter_pkg.sv
// Shared constants for the multi-digit counter: digit width and active-low
// seven-segment patterns (bit order gfedcba).
package multi_digit_counter_pkg;

    localparam int unsigned DigitW = 4;

    localparam logic [6:0] Seg0     = 7'b1000000;
    localparam logic [6:0] Seg1     = 7'b1111001;
    localparam logic [6:0] Seg2     = 7'b0100100;
    localparam logic [6:0] Seg3     = 7'b0110000;
    localparam logic [6:0] Seg4     = 7'b0011001;
    localparam logic [6:0] Seg5     = 7'b0010010;
    localparam logic [6:0] Seg6     = 7'b0000010;
    localparam logic [6:0] Seg7     = 7'b1111000;
    localparam logic [6:0] Seg8     = 7'b0000000;
    localparam logic [6:0] Seg9     = 7'b0010000;
    localparam logic [6:0] SegA     = 7'b0001000;
    localparam logic [6:0] SegB     = 7'b0000011;
    localparam logic [6:0] SegC     = 7'b1000110;
    localparam logic [6:0] SegD     = 7'b0100001;
    localparam logic [6:0] SegE     = 7'b0000110;
    localparam logic [6:0] SegF     = 7'b0001110;
    localparam logic [6:0] SegBlank = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Hex digit to active-low seven-segment decoder (gfedcba).
module seg7_decode
    import multi_digit_counter_pkg::*;
(
    input  logic [DigitW-1:0] digit,
    output logic [6:0]        seg
);

    always_comb begin
        seg = SegBlank;
        unique case (digit)
            4'h0: seg = Seg0;
            4'h1: seg = Seg1;
            4'h2: seg = Seg2;
            4'h3: seg = Seg3;
            4'h4: seg = Seg4;
            4'h5: seg = Seg5;
            4'h6: seg = Seg6;
            4'h7: seg = Seg7;
            4'h8: seg = Seg8;
            4'h9: seg = Seg9;
            4'hA: seg = SegA;
            4'hB: seg = SegB;
            4'hC: seg = SegC;
            4'hD: seg = SegD;
            4'hE: seg = SegE;
            4'hF: seg = SegF;
        endcase
    end

endmodule

// File: rtl/multi_digit_counter.sv
// Prescaled up/down multi-digit counter in base RADIX with load, wrap strobe
// and per-digit seven-segment outputs.
module multi_digit_counter
    import multi_digit_counter_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 25000000,
    parameter int unsigned RADIX  = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     up,
    input  logic                     load,
    input  logic [DigitW*DIGITS-1:0] load_val,
    output logic [DigitW*DIGITS-1:0] value,
    output logic                     tick,
    output logic                     carry,
    output logic [7*DIGITS-1:0]      seg
);

    localparam int unsigned ValW = DigitW * DIGITS;
    localparam logic [31:0] PreLast = 32'(DIV - 1);
    localparam logic [DigitW-1:0] DigitMax = DigitW'(RADIX - 1);

    logic [31:0]       pre_q, pre_d;
    logic [ValW-1:0]   value_q, value_d;
    logic              carry_q, carry_d;
    logic [ValW-1:0]   step_val, load_clamped;
    logic [DigitW-1:0] step_digit, load_digit;
    logic              wrap;

    // Reset gates tick so it reads 0 during reset even with DIV=1.
    always_comb tick = reset & en & (pre_q == PreLast);

    always_comb begin
        pre_d = '0;
        if (!load && en && (pre_q != PreLast)) begin
            pre_d = pre_q + 32'd1;
        end
    end

    // Ripple carry/borrow from digit 0 upward; wrap means it left the top digit.
    always_comb begin
        step_val   = value_q;
        step_digit = '0;
        wrap       = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            step_digit = value_q[i*DigitW +: DigitW];
            if (wrap) begin
                if (up) begin
                    if (step_digit == DigitMax) begin
                        step_digit = '0;
                    end else begin
                        step_digit = step_digit + 1'b1;
                        wrap       = 1'b0;
                    end
                end else begin
                    if (step_digit == '0) begin
                        step_digit = DigitMax;
                    end else begin
                        step_digit = step_digit - 1'b1;
                        wrap       = 1'b0;
                    end
                end
            end
            step_val[i*DigitW +: DigitW] = step_digit;
        end
    end

    always_comb begin
        load_clamped = '0;
        load_digit   = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            load_digit = load_val[i*DigitW +: DigitW];
            load_clamped[i*DigitW +: DigitW] = (load_digit > DigitMax) ? DigitMax : load_digit;
        end
    end

    always_comb begin
        value_d = value_q;
        carry_d = 1'b0;
        if (load) begin
            value_d = load_clamped;
        end else if (tick) begin
            value_d = step_val;
            carry_d = wrap;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q   <= '0;
            value_q <= '0;
            carry_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            value_q <= value_d;
            carry_q <= carry_d;
        end
    end

    assign value = value_q;
    assign carry = carry_q;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        seg7_decode u_seg (
            .digit (value_q[g*DigitW +: DigitW]),
            .seg   (seg[g*7 +: 7])
        );
    end

endmodule

// File: tb/tb_multi_digit_counter.sv
// Bench for multi_digit_counter (2 digits, DIV=4, base 10): integer-count
// model compared every cycle, plus directed literal expectations.
module tb_multi_digit_counter;

    localparam int DIGITS = 2;
    localparam int DIV    = 4;
    localparam int RADIX  = 10;
    localparam int MOD    = RADIX * RADIX;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        up;
    logic        load;
    logic [7:0]  load_val;
    logic [7:0]  value;
    logic        tick;
    logic        carry;
    logic [13:0] seg;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 0;

    int m_cnt   = 0;
    int m_pre   = 0;
    bit m_carry = 0;
    bit m_tick;

    multi_digit_counter #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .RADIX  (RADIX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .value    (value),
        .tick     (tick),
        .carry    (carry),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] exp_value(input int c);
        return {4'((c / RADIX) % RADIX), 4'(c % RADIX)};
    endfunction

    function automatic logic [13:0] exp_seg(input int c);
        return {seg_of((c / RADIX) % RADIX), seg_of(c % RADIX)};
    endfunction

    function automatic int clamp_load(input logic [7:0] v);
        int lo, hi;
        lo = int'(v[3:0]);
        hi = int'(v[7:4]);
        if (lo > RADIX - 1) lo = RADIX - 1;
        if (hi > RADIX - 1) hi = RADIX - 1;
        return hi * RADIX + lo;
    endfunction

    // Model: count as a plain integer mod RADIX^DIGITS.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt   = 0;
            m_pre   = 0;
            m_carry = 0;
        end else begin
            m_tick  = en && (m_pre == DIV - 1);
            m_carry = 0;
            if (load) begin
                m_cnt = clamp_load(load_val);
                m_pre = 0;
            end else begin
                if (m_tick) begin
                    if (up) begin
                        m_carry = (m_cnt == MOD - 1);
                        m_cnt   = (m_cnt + 1) % MOD;
                    end else begin
                        m_carry = (m_cnt == 0);
                        m_cnt   = (m_cnt + MOD - 1) % MOD;
                    end
                end
                m_pre = (en && !m_tick) ? m_pre + 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_value", 32'(value), 32'(exp_value(m_cnt)));
            check("model_tick", 32'(tick), 32'(reset && en && (m_pre == DIV - 1)));
            check("model_carry", 32'(carry), 32'(m_carry));
            check("model_seg", 32'(seg), 32'(exp_seg(m_cnt)));
        end
    end

    task automatic do_load(input logic [7:0] v);
        @(posedge clk);
        #1;
        load     = 1'b1;
        load_val = v;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    initial begin : stim
        int ticks;
        reset    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;
        @(posedge clk);
        #1;
        cmp_on = 1;
        @(negedge clk);
        check("rst_value", 32'(value), 32'h00);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_carry", 32'(carry), 32'h0);
        check("rst_seg", 32'(seg), 32'(14'b1000000_1000000));

        // Count up from reset: tick on the 4th cycle, 0x10 after ten ticks.
        @(posedge clk);
        #1;
        reset = 1'b1;
        en    = 1'b1;
        for (int n = 1; n <= 41; n++) begin
            @(negedge clk);
            if (n == 3) check("first_tick_early", 32'(tick), 32'h0);
            if (n == 4) check("first_tick", 32'(tick), 32'h1);
            if (n == 5) begin
                check("count_01", 32'(value), 32'h01);
                check("seg_01", 32'(seg[6:0]), 32'(7'b1111001));
            end
            if (n == 41) check("count_10", 32'(value), 32'h10);
        end

        // Wrap 99 -> 00 with a single carry pulse.
        do_load(8'h99);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) check("load_99", 32'(value), 32'h99);
            if (n == 5) begin
                check("wrap_value", 32'(value), 32'h00);
                check("wrap_carry", 32'(carry), 32'h1);
            end
            if (n == 6) check("wrap_carry_end", 32'(carry), 32'h0);
        end

        // Borrow 00 -> 99.
        up = 1'b0;
        do_load(8'h00);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 5) begin
                check("borrow_value", 32'(value), 32'h99);
                check("borrow_carry", 32'(carry), 32'h1);
            end
            if (n == 6) check("borrow_carry_end", 32'(carry), 32'h0);
        end

        // Clamped load, then a load landing on a tick cycle.
        do_load(8'hFA);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 1) check("clamp_value", 32'(value), 32'h99);
            check("clamp_no_carry", 32'(carry), 32'h0);
            @(posedge clk);
            #1;
        end
        load     = 1'b1;
        load_val = 8'h42;
        up       = 1'b1;
        @(negedge clk);
        check("load_tick_coincide", 32'(tick), 32'h1);
        @(posedge clk);
        #1;
        load = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) check("load_over_tick", 32'(value), 32'h42);
            if (n == 3) check("post_load_tick_early", 32'(tick), 32'h0);
            if (n == 4) check("post_load_tick", 32'(tick), 32'h1);
            if (n == 5) check("post_load_count", 32'(value), 32'h43);
        end

        // Asynchronous reset between edges mid-count.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_value", 32'(value), 32'h00);
        check("async_carry", 32'(carry), 32'h0);
        check("async_tick", 32'(tick), 32'h0);
        check("async_seg", 32'(seg), 32'(14'b1000000_1000000));
        en = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        ticks = 0;
        repeat (20) begin
            @(negedge clk);
            if (tick) ticks++;
        end
        check("en0_no_tick", 32'(ticks), 32'h0);
        check("en0_hold", 32'(value), 32'h00);

        cmp_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
